lut_table_loader: RTL

- Runtime writer for LogicNets-style neuron truth tables: accepts table-load frames on a valid/ready config stream and stores them into NUM_NEURONS table registers of 2**FANIN bits each.
- Evaluates all neurons from the active tables, one registered cycle per evaluation.
- Sits beside a layer in place of hard-coded neuron ROMs, so layer functions can be reprogrammed without resynthesis.
- Frames are staged in a shadow buffer and committed atomically; a neuron never evaluates against a partially loaded table.

---
 rtl/lut_table_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/lut_table_loader.sv
// lut_table_loader: runtime-loadable neuron truth tables, shadow-staged and committed atomically.
// Define LUT_LOADER_CHECKSUM_EN to require a trailing XOR checksum word on every frame.
module lut_table_loader #(
  parameter int NUM_NEURONS = 8,
  parameter int FANIN = 6,
  parameter int WORD_W = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [WORD_W-1:0]            cfg_data,
  input  logic                         cfg_last,
  output logic                         load_done,
  output logic                         load_err,
  input  logic                         eval_valid,
  input  logic [NUM_NEURONS*FANIN-1:0] eval_addr,
  output logic                         out_valid,
  output logic [NUM_NEURONS-1:0]       out_bits
);
  localparam int DEPTH = 2**FANIN;
  localparam int WPT = DEPTH / WORD_W;
  localparam int CW = WPT > 1 ? $clog2(WPT) : 1;
  localparam int NW = NUM_NEURONS > 1 ? $clog2(NUM_NEURONS) : 1;
  // one bit wider than the table index so power-of-two banks can still flag out-of-range headers
  localparam int IW = $clog2(NUM_NEURONS + 1);
  localparam logic [IW-1:0] NN = IW'(NUM_NEURONS);
`ifdef LUT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, DATA, DRAIN, CHECK, COMMIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, DATA, DRAIN, COMMIT} state_t;
`endif
  state_t state, nstate;
  logic [CW-1:0] cnt;
  logic [NW-1:0] idx;
  logic bad, err, acc, cnt_max;
  logic [DEPTH-1:0] shadow;
  logic [NUM_NEURONS-1:0][DEPTH-1:0] tables;
  logic [NUM_NEURONS-1:0] lookup;
`ifdef LUT_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] ck;
`endif
  assign cfg_ready = state != COMMIT;
  assign acc = cfg_valid && cfg_ready;
  assign cnt_max = cnt == CW'(WPT - 1);
  always_comb begin
    nstate = state;
    err = 1'b0;
    case (state)
      IDLE: if (acc) begin
        nstate = cfg_last ? IDLE : DATA;
        err = cfg_last;
      end
      DATA: if (acc && (cfg_last || cnt_max)) begin
`ifdef LUT_LOADER_CHECKSUM_EN
        nstate = cfg_last ? IDLE : CHECK;
        err = cfg_last;
`else
        nstate = !cfg_last ? DRAIN : (!cnt_max || bad) ? IDLE : COMMIT;
        err = cfg_last && (!cnt_max || bad);
`endif
      end
`ifdef LUT_LOADER_CHECKSUM_EN
      CHECK: if (acc) begin
        nstate = !cfg_last ? DRAIN : (bad || ck != cfg_data) ? IDLE : COMMIT;
        err = cfg_last && (bad || ck != cfg_data);
      end
`endif
      DRAIN: if (acc && cfg_last) begin
        nstate = IDLE;
        err = 1'b1;
      end
      COMMIT: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end
  always_comb begin
    lookup = '0;
    for (int n = 0; n < NUM_NEURONS; n++) lookup[n] = tables[n][eval_addr[n*FANIN +: FANIN]];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      bad <= 1'b0;
      shadow <= '0;
      tables <= '0;
      load_done <= 1'b0;
      load_err <= 1'b0;
      out_valid <= 1'b0;
      out_bits <= '0;
    end else begin
      state <= nstate;
      load_done <= state == COMMIT;
      load_err <= err;
      out_valid <= eval_valid;
      if (eval_valid) out_bits <= lookup;
      if (acc && state == IDLE) begin
        idx <= cfg_data[NW-1:0];
        bad <= cfg_data[IW-1:0] >= NN;
        cnt <= '0;
      end
      if (acc && state == DATA) begin
        for (int k = 0; k < WPT; k++) if (cnt == CW'(k)) shadow[k*WORD_W +: WORD_W] <= cfg_data;
        cnt <= cnt + 1'b1;
      end
      if (state == COMMIT) tables[idx] <= shadow;
    end
  end
`ifdef LUT_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ck <= '0;
    else if (acc && state == IDLE) ck <= cfg_data;
    else if (acc && state == DATA) ck <= ck ^ cfg_data;
  end
`endif
endmodule
